// File: rtl/prbs_checker.sv
// PRBS-16 word checker (x^16+x^14+x^13+x^11, 4 bits/word): seeds from 4 words, then predicts each word.
// Latency: all outputs registered, 1 cycle after the word; no backpressure, i_valid=0 cycles simply stall.
module prbs_checker #(
    parameter int LOSS_THRESH = 3,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_valid,
    input  logic [3:0]           i_data,
    output logic                 o_locked,
    output logic                 o_err,
    output logic                 o_lock_lost,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    localparam int MISS_W = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEED  = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    state_e                 state_q,  state_d;
    logic                   start_q;
    logic [15:0]            seed_q,   seed_d;
    logic [1:0]             wcnt_q,   wcnt_d;
    logic [15:0]            lfsr_q,   lfsr_d;
    logic [MISS_W-1:0]      miss_q,   miss_d;
    logic                   locked_q, locked_d;
    logic                   err_q,    err_d;
    logic                   lost_q,   lost_d;
    logic [ERR_CNT_W-1:0]   cnt_q,    cnt_d;

    logic [15:0]            seed_nxt;
    logic [15:0]            pred;
    logic [MISS_W-1:0]      miss_inc;

    function automatic logic [15:0] lfsr_adv4(input logic [15:0] s);
        logic [15:0] t;
        t = s;
        for (int i = 0; i < 4; i++) begin
            t = {t[14:0], t[15] ^ t[13] ^ t[12] ^ t[10]};
        end
        return t;
    endfunction

    assign seed_nxt = {seed_q[11:0], i_data};
    assign pred     = lfsr_adv4(lfsr_q);
    assign miss_inc = miss_q + MISS_W'(1);

    always_comb begin
        state_d  = state_q;
        seed_d   = seed_q;
        wcnt_d   = wcnt_q;
        lfsr_d   = lfsr_q;
        miss_d   = miss_q;
        locked_d = locked_q;
        err_d    = 1'b0;
        lost_d   = 1'b0;
        cnt_d    = cnt_q;

        if (!i_start) begin
            state_d  = ST_IDLE;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!start_q) begin
                        state_d = ST_SEED;
                        cnt_d   = '0;
                        seed_d  = '0;
                        wcnt_d  = '0;
                        miss_d  = '0;
                    end
                end
                ST_SEED: begin
                    if (i_valid) begin
                        seed_d = seed_nxt;
                        wcnt_d = wcnt_q + 2'd1;
                        // an all-zero seed would lock the LFSR at zero; the wrapped counter restarts seeding
                        if (wcnt_q == 2'd3 && seed_nxt != 16'h0000) begin
                            state_d  = ST_CHECK;
                            lfsr_d   = seed_nxt;
                            locked_d = 1'b1;
                            miss_d   = '0;
                        end
                    end
                end
                ST_CHECK: begin
                    if (i_valid) begin
                        lfsr_d = pred;
                        if (pred[3:0] != i_data) begin
                            err_d = 1'b1;
                            if (!(&cnt_q)) begin
                                cnt_d = cnt_q + ERR_CNT_W'(1);
                            end
                            if (miss_inc == MISS_W'(LOSS_THRESH)) begin
                                state_d  = ST_SEED;
                                locked_d = 1'b0;
                                lost_d   = 1'b1;
                                wcnt_d   = '0;
                                miss_d   = '0;
                            end else begin
                                miss_d = miss_inc;
                            end
                        end else begin
                            miss_d = '0;
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            // held high so a start level already present at release is not seen as a rising edge
            start_q  <= 1'b1;
            seed_q   <= '0;
            wcnt_q   <= '0;
            lfsr_q   <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            lost_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= i_start;
            seed_q   <= seed_d;
            wcnt_q   <= wcnt_d;
            lfsr_q   <= lfsr_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            lost_q   <= lost_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_locked    = locked_q;
    assign o_err       = err_q;
    assign o_lock_lost = lost_q;
    assign o_err_cnt   = cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: vector table plus sequences for reset, long clean run and saturation.
module tb_prbs_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        valid;
    logic [3:0]  data;
    logic        locked, err, lost;
    logic [15:0] cnt;
    logic        s_locked, s_err, s_lost;
    logic [3:0]  s_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] g;

    localparam logic [1:0] LIT = 2'd0;
    localparam logic [1:0] GEN = 2'd1;
    localparam logic [1:0] BAD = 2'd2;

    typedef struct {
        logic        st;
        logic        v;
        logic [1:0]  dsel;
        logic [3:0]  lit;
        logic        e_lk;
        logic        e_err;
        logic        e_lost;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    prbs_checker dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid), .i_data(data),
        .o_locked(locked), .o_err(err), .o_lock_lost(lost), .o_err_cnt(cnt)
    );

    prbs_checker #(.LOSS_THRESH(3), .ERR_CNT_W(4)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid), .i_data(data),
        .o_locked(s_locked), .o_err(s_err), .o_lock_lost(s_lost), .o_err_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // generator: taps 15,13,12,10 as a mask, new bit enters at bit 0
    task automatic gen_next(output logic [3:0] w);
        for (int i = 0; i < 4; i++) begin
            g = {g[14:0], ^(g & 16'hB400)};
        end
        w = g[3:0];
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic st, input logic v, input logic [1:0] ds,
                                input logic [3:0] lit, input logic lk, input logic er,
                                input logic lo, input logic [15:0] c);
        vec_t r;
        r.st = st; r.v = v; r.dsel = ds; r.lit = lit;
        r.e_lk = lk; r.e_err = er; r.e_lost = lo; r.e_cnt = c;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] w;
        int         errs, losts, unl, s_errs;
        logic       any_lock;

        //                 st  v  dsel lit  lk er lo cnt
        tbl.push_back(mk(0, 0, LIT, 0, 0, 0, 0, 0));  // 0
        tbl.push_back(mk(1, 1, LIT, 5, 0, 0, 0, 0));  // 1 rise, word ignored
        tbl.push_back(mk(1, 1, GEN, 0, 0, 0, 0, 0));  // 2 seed 1
        tbl.push_back(mk(1, 0, LIT, 9, 0, 0, 0, 0));  // 3 gap in SEED
        tbl.push_back(mk(1, 1, GEN, 0, 0, 0, 0, 0));  // 4 seed 2
        tbl.push_back(mk(1, 1, GEN, 0, 0, 0, 0, 0));  // 5 seed 3
        tbl.push_back(mk(1, 1, GEN, 0, 1, 0, 0, 0));  // 6 seed 4 -> lock
        tbl.push_back(mk(1, 1, GEN, 0, 1, 0, 0, 0));  // 7
        tbl.push_back(mk(1, 0, LIT, 3, 1, 0, 0, 0));  // 8 gap
        tbl.push_back(mk(1, 1, GEN, 0, 1, 0, 0, 0));  // 9
        tbl.push_back(mk(1, 1, BAD, 0, 1, 1, 0, 1));  // 10 single error
        tbl.push_back(mk(1, 1, GEN, 0, 1, 0, 0, 1));  // 11
        tbl.push_back(mk(1, 1, GEN, 0, 1, 0, 0, 1));  // 12
        tbl.push_back(mk(0, 1, GEN, 0, 0, 0, 0, 1));  // 13 drop start, count held
        tbl.push_back(mk(0, 0, LIT, 0, 0, 0, 0, 1));  // 14
        tbl.push_back(mk(1, 1, GEN, 0, 0, 0, 0, 0));  // 15 re-raise clears count
        tbl.push_back(mk(1, 1, GEN, 0, 0, 0, 0, 0));  // 16
        tbl.push_back(mk(1, 1, GEN, 0, 0, 0, 0, 0));  // 17
        tbl.push_back(mk(1, 1, GEN, 0, 0, 0, 0, 0));  // 18
        tbl.push_back(mk(1, 1, GEN, 0, 1, 0, 0, 0));  // 19 lock
        tbl.push_back(mk(1, 1, GEN, 0, 1, 0, 0, 0));  // 20
        tbl.push_back(mk(1, 1, BAD, 0, 1, 1, 0, 1));  // 21 miss 1
        tbl.push_back(mk(1, 1, GEN, 0, 1, 0, 0, 1));  // 22 match clears miss
        tbl.push_back(mk(1, 1, BAD, 0, 1, 1, 0, 2));  // 23 miss 1
        tbl.push_back(mk(1, 1, BAD, 0, 1, 1, 0, 3));  // 24 miss 2
        tbl.push_back(mk(1, 0, LIT, 7, 1, 0, 0, 3));  // 25 gap keeps miss
        tbl.push_back(mk(1, 1, BAD, 0, 0, 1, 1, 4));  // 26 miss 3 -> lock lost
        tbl.push_back(mk(1, 0, LIT, 0, 0, 0, 0, 4));  // 27
        tbl.push_back(mk(1, 1, GEN, 0, 0, 0, 0, 4));  // 28
        tbl.push_back(mk(1, 1, GEN, 0, 0, 0, 0, 4));  // 29
        tbl.push_back(mk(1, 1, GEN, 0, 0, 0, 0, 4));  // 30
        tbl.push_back(mk(1, 1, GEN, 0, 1, 0, 0, 4));  // 31 relock
        tbl.push_back(mk(1, 1, GEN, 0, 1, 0, 0, 4));  // 32
        tbl.push_back(mk(0, 0, LIT, 0, 0, 0, 0, 4));  // 33 idle
        tbl.push_back(mk(1, 0, LIT, 0, 0, 0, 0, 0));  // 34 rise
        tbl.push_back(mk(1, 1, LIT, 0, 0, 0, 0, 0));  // 35 zero seed
        tbl.push_back(mk(1, 1, LIT, 0, 0, 0, 0, 0));  // 36
        tbl.push_back(mk(1, 1, LIT, 0, 0, 0, 0, 0));  // 37
        tbl.push_back(mk(1, 1, LIT, 0, 0, 0, 0, 0));  // 38 no lock
        tbl.push_back(mk(1, 1, GEN, 0, 0, 0, 0, 0));  // 39
        tbl.push_back(mk(1, 1, GEN, 0, 0, 0, 0, 0));  // 40
        tbl.push_back(mk(1, 1, GEN, 0, 0, 0, 0, 0));  // 41
        tbl.push_back(mk(1, 1, GEN, 0, 1, 0, 0, 0));  // 42 lock
        tbl.push_back(mk(1, 1, GEN, 0, 1, 0, 0, 0));  // 43
        tbl.push_back(mk(1, 1, GEN, 0, 1, 0, 0, 0));  // 44
        tbl.push_back(mk(1, 1, BAD, 0, 1, 1, 0, 1));  // 45

        rst_n = 1'b1; start = 1'b0; valid = 1'b0; data = 4'h0; g = 16'hACE1;
        #2 rst_n = 1'b0;
        #2;
        chk("reset locked", 16'(locked), 16'h0);
        chk("reset err",    16'(err),    16'h0);
        chk("reset lost",   16'(lost),   16'h0);
        chk("reset cnt",    cnt,         16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            start = tbl[i].st;
            valid = tbl[i].v;
            if (tbl[i].dsel == LIT) begin
                data = tbl[i].lit;
            end else begin
                gen_next(w);
                data = w ^ {3'b000, tbl[i].dsel == BAD};
            end
            cycle();
            chk($sformatf("row%0d locked", i), 16'(locked), 16'(tbl[i].e_lk));
            chk($sformatf("row%0d err", i),    16'(err),    16'(tbl[i].e_err));
            chk($sformatf("row%0d lost", i),   16'(lost),   16'(tbl[i].e_lost));
            chk($sformatf("row%0d cnt", i),    cnt,         tbl[i].e_cnt);
        end

        // async reset mid-CHECK, between edges, with start held high across release
        #2 rst_n = 1'b0;
        #1;
        chk("arst locked", 16'(locked), 16'h0);
        chk("arst err",    16'(err),    16'h0);
        chk("arst lost",   16'(lost),   16'h0);
        chk("arst cnt",    cnt,         16'h0);
        #1 rst_n = 1'b1;
        any_lock = 1'b0;
        valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            gen_next(w);
            data = w;
            cycle();
            any_lock |= locked;
        end
        chk("no relock without start edge", 16'(any_lock), 16'h0);
        start = 1'b0; valid = 1'b0;
        cycle();
        start = 1'b1;
        cycle();
        valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            gen_next(w);
            data = w;
            cycle();
            if (k == 3) chk("post-reset locked after word 3", 16'(locked), 16'h0);
            if (k == 4) chk("post-reset locked after word 4", 16'(locked), 16'h1);
            if (k == 5) chk("post-reset err", 16'(err), 16'h0);
        end

        // clean run from seed 0xACE1; gaps inserted in the second half
        start = 1'b0; valid = 1'b0;
        cycle();
        g = 16'hACE1;
        start = 1'b1;
        cycle();
        errs = 0; losts = 0; unl = 0;
        for (int k = 1; k <= 200; k++) begin
            if (k > 100 && $urandom_range(0, 3) == 0) begin
                valid = 1'b0;
                data  = 4'($urandom);
                cycle();
                errs  += int'(err);
                losts += int'(lost);
                if (!locked) unl++;
            end
            gen_next(w);
            valid = 1'b1;
            data  = w;
            cycle();
            if (k == 3) chk("clean locked after word 3", 16'(locked), 16'h0);
            if (k == 4) chk("clean locked after word 4", 16'(locked), 16'h1);
            errs  += int'(err);
            losts += int'(lost);
            if (k >= 4 && !locked) unl++;
        end
        chk("clean err pulses",  16'(errs),  16'h0);
        chk("clean lost pulses", 16'(losts), 16'h0);
        chk("clean unlocked",    16'(unl),   16'h0);
        chk("clean cnt",         cnt,        16'h0);

        // 20 isolated errors: 4-bit counter sticks at 15
        errs = 0; s_errs = 0; losts = 0;
        for (int k = 0; k < 20; k++) begin
            gen_next(w);
            data = w ^ 4'h1;
            cycle();
            errs   += int'(err);
            s_errs += int'(s_err);
            losts  += int'(lost) + int'(s_lost);
            for (int j = 0; j < 2; j++) begin
                gen_next(w);
                data = w;
                cycle();
                errs   += int'(err);
                s_errs += int'(s_err);
            end
        end
        chk("sat err pulses",       16'(errs),     16'd20);
        chk("sat small err pulses", 16'(s_errs),   16'd20);
        chk("sat lost pulses",      16'(losts),    16'd0);
        chk("sat small cnt",        16'(s_cnt),    16'd15);
        chk("sat wide cnt",         cnt,           16'd20);
        chk("sat small locked",     16'(s_locked), 16'h1);
        chk("sat locked",           16'(locked),   16'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
